// File: rtl/axis_desc_arbiter_pkg.sv
// Shared types and defaults for the pixel/weight descriptor arbiter:
// FSM state encoding, requester tag encoding and default widths.
package axis_desc_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_STS = 2'd2
  } state_e;

  localparam logic TAG_PIX = 1'b0;
  localparam logic TAG_WT  = 1'b1;

  localparam int DEF_ADDR_WIDTH     = 32;
  localparam int DEF_LEN_WIDTH      = 23;
  localparam int DEF_CNT_WIDTH      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/axis_desc_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone request always wins, a tie goes to the
// requester named by pointer (index 0 = pixels, 1 = weights). Grant is one-hot or zero.
module rr_arb2
  import axis_desc_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       pointer,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (pointer == TAG_WT) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/axis_desc_arbiter.sv
// Arbitrates pixel and weight descriptor requests onto one DMA descriptor channel,
// one descriptor outstanding at a time. Define DESC_TIMEOUT_EN to add the status watchdog.
module axis_desc_arbiter
  import axis_desc_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH      = DEF_LEN_WIDTH,
  parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_pix_valid,
  output logic                  s_pix_ready,
  input  logic [ADDR_WIDTH-1:0] s_pix_addr,
  input  logic [LEN_WIDTH-1:0]  s_pix_len,
  input  logic                  s_wt_valid,
  output logic                  s_wt_ready,
  input  logic [ADDR_WIDTH-1:0] s_wt_addr,
  input  logic [LEN_WIDTH-1:0]  s_wt_len,
  output logic                  m_desc_valid,
  input  logic                  m_desc_ready,
  output logic [ADDR_WIDTH-1:0] m_desc_addr,
  output logic [LEN_WIDTH-1:0]  m_desc_len,
  output logic                  m_desc_tag,
  input  logic                  s_sts_valid,
  output logic                  s_sts_ready,
  input  logic                  s_sts_err,
  output logic                  pix_done,
  output logic                  wt_done,
  output logic                  done_err,
  output logic [CNT_WIDTH-1:0]  pix_count,
  output logic [CNT_WIDTH-1:0]  wt_count,
  output logic                  busy,
  output logic                  timeout_flag,
  output state_e                dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; a source holds valid and its payload stable until that edge.
  state_e                state_q, state_d;
  logic                  ptr_q, ptr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  tag_q, tag_d;
  logic                  pix_done_q, pix_done_d;
  logic                  wt_done_q, wt_done_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  pix_cnt_q, pix_cnt_d;
  logic [CNT_WIDTH-1:0]  wt_cnt_q, wt_cnt_d;
  logic [1:0]            grant;
  logic                  accept, sts_done, wd_expired, complete;

  rr_arb2 u_rr_arb2 (
    .req     ({s_wt_valid, s_pix_valid}),
    .pointer (ptr_q),
    .grant   (grant)
  );

  assign accept   = (s_pix_valid & s_pix_ready) | (s_wt_valid & s_wt_ready);
  assign sts_done = (state_q == ST_WAIT_STS) & s_sts_valid;
  assign complete = sts_done | wd_expired;

`ifdef DESC_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd_q, wd_d;
  logic            tmo_flag_q, tmo_flag_d;

  // A status arriving on the expiry cycle wins, so expiry requires no status.
  assign wd_expired = (state_q == ST_WAIT_STS) && !s_sts_valid &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d       = (state_q == ST_WAIT_STS) ? wd_q + WD_W'(1) : '0;
    tmo_flag_d = tmo_flag_q | wd_expired;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wd_q       <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  assign timeout_flag = tmo_flag_q;
`else
  assign wd_expired   = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (accept)       state_d = ST_ISSUE;
      ST_ISSUE:    if (m_desc_ready) state_d = ST_WAIT_STS;
      ST_WAIT_STS: if (complete)     state_d = ST_IDLE;
      default:                       state_d = ST_IDLE;
    endcase
  end

  // Readies are also gated by reset so nothing is offered while reset is held.
  always_comb begin
    s_pix_ready  = 1'b0;
    s_wt_ready   = 1'b0;
    m_desc_valid = 1'b0;
    s_sts_ready  = 1'b0;
    busy         = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy        = 1'b0;
        s_pix_ready = aresetn & grant[0];
        s_wt_ready  = aresetn & grant[1];
      end
      ST_ISSUE:    m_desc_valid = 1'b1;
      ST_WAIT_STS: s_sts_ready  = 1'b1;
      default:     busy         = 1'b1;
    endcase
  end

  always_comb begin
    ptr_d      = ptr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    tag_d      = tag_q;
    pix_done_d = 1'b0;
    wt_done_d  = 1'b0;
    err_d      = 1'b0;
    pix_cnt_d  = pix_cnt_q;
    wt_cnt_d   = wt_cnt_q;
    if (accept) begin
      if (s_wt_ready) begin
        tag_d  = TAG_WT;
        addr_d = s_wt_addr;
        len_d  = s_wt_len;
      end else begin
        tag_d  = TAG_PIX;
        addr_d = s_pix_addr;
        len_d  = s_pix_len;
      end
    end
    if (complete) begin
      ptr_d = ~tag_q;
      err_d = sts_done ? s_sts_err : 1'b1;
      if (tag_q == TAG_WT) begin
        wt_done_d = 1'b1;
        wt_cnt_d  = wt_cnt_q + CNT_WIDTH'(1);
      end else begin
        pix_done_d = 1'b1;
        pix_cnt_d  = pix_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ptr_q      <= TAG_WT;
      addr_q     <= '0;
      len_q      <= '0;
      tag_q      <= 1'b0;
      pix_done_q <= 1'b0;
      wt_done_q  <= 1'b0;
      err_q      <= 1'b0;
      pix_cnt_q  <= '0;
      wt_cnt_q   <= '0;
    end else begin
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      tag_q      <= tag_d;
      pix_done_q <= pix_done_d;
      wt_done_q  <= wt_done_d;
      err_q      <= err_d;
      pix_cnt_q  <= pix_cnt_d;
      wt_cnt_q   <= wt_cnt_d;
    end
  end

  assign m_desc_addr = addr_q;
  assign m_desc_len  = len_q;
  assign m_desc_tag  = tag_q;
  assign pix_done    = pix_done_q;
  assign wt_done     = wt_done_q;
  assign done_err    = err_q;
  assign pix_count   = pix_cnt_q;
  assign wt_count    = wt_cnt_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_axis_desc_arbiter.sv
// Bench for axis_desc_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (grant rule, descriptor queue, completion counts).
module tb_axis_desc_arbiter;
  import axis_desc_arbiter_pkg::*;

  localparam int AW = 32;
  localparam int LW = 23;
  localparam int CW = 4;
  localparam int TO = 16;
  localparam int DW = 1 + AW + LW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_pix_valid, s_pix_ready, s_wt_valid, s_wt_ready;
  logic [AW-1:0] s_pix_addr, s_wt_addr, m_desc_addr;
  logic [LW-1:0] s_pix_len, s_wt_len, m_desc_len;
  logic          m_desc_valid, m_desc_ready, m_desc_tag;
  logic          s_sts_valid, s_sts_ready, s_sts_err;
  logic          pix_done, wt_done, done_err, busy, timeout_flag;
  logic [CW-1:0] pix_count, wt_count;
  state_e        dbg_state;

  always #5 aclk = ~aclk;

  axis_desc_arbiter #(
    .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_pix_valid(s_pix_valid), .s_pix_ready(s_pix_ready),
    .s_pix_addr(s_pix_addr), .s_pix_len(s_pix_len),
    .s_wt_valid(s_wt_valid), .s_wt_ready(s_wt_ready),
    .s_wt_addr(s_wt_addr), .s_wt_len(s_wt_len),
    .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
    .m_desc_addr(m_desc_addr), .m_desc_len(m_desc_len), .m_desc_tag(m_desc_tag),
    .s_sts_valid(s_sts_valid), .s_sts_ready(s_sts_ready), .s_sts_err(s_sts_err),
    .pix_done(pix_done), .wt_done(wt_done), .done_err(done_err),
    .pix_count(pix_count), .wt_count(wt_count),
    .busy(busy), .timeout_flag(timeout_flag), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: protocol phase, tie-break owner, queue of accepted descriptors.
  typedef enum {M_IDLE, M_ISSUE, M_WAIT} mphase_e;
  mphase_e       mph;
  logic          m_ptr;
  logic [DW-1:0] exp_q[$];
  logic          acc_tags[$];
  bit            pend;
  logic          pend_tag, pend_err;
  int            n_pix, n_wt, n_total, wait_n;
  logic          m_flag;

  int p_pix, p_wt, p_mrdy, p_sts, p_err;
  bit hs_pix, hs_wt;

  task automatic model_reset();
    mph = M_IDLE;
    m_ptr = 1'b1;
    exp_q.delete();
    acc_tags.delete();
    pend = 0;
    n_pix = 0;
    n_wt = 0;
    wait_n = 0;
    m_flag = 1'b0;
  endtask

  task automatic finish_desc(input logic err, input logic tmo);
    pend = 1;
    pend_tag = exp_q[0][DW-1];
    pend_err = err;
    void'(exp_q.pop_front());
    m_ptr = ~pend_tag;
    if (tmo) m_flag = 1'b1;
    n_total++;
    mph = M_IDLE;
  endtask

  task automatic monitor();
    logic [1:0] exp_rdy;
    if (pend) begin
      check_eq("done_pulse", 64'({pix_done, wt_done, done_err}),
               64'({pend_tag == 1'b0, pend_tag == 1'b1, pend_err}));
      if (pend_tag) n_wt++;
      else n_pix++;
      pend = 0;
    end else begin
      check_eq("no_done", 64'({pix_done, wt_done, done_err}), 64'd0);
      check_eq("pix_count", 64'(pix_count), 64'(n_pix % 16));
      check_eq("wt_count", 64'(wt_count), 64'(n_wt % 16));
    end
    check_eq("busy", 64'(busy), 64'(mph != M_IDLE));
    check_eq("timeout_flag", 64'(timeout_flag), 64'(m_flag));
    hs_pix = s_pix_valid && s_pix_ready;
    hs_wt  = s_wt_valid && s_wt_ready;
    case (mph)
      M_IDLE: begin
        if (s_pix_valid && s_wt_valid) exp_rdy = m_ptr ? 2'b10 : 2'b01;
        else exp_rdy = {s_wt_valid, s_pix_valid};
        check_eq("req_ready", 64'({s_wt_ready, s_pix_ready}), 64'(exp_rdy));
        check_eq("idle_quiet", 64'({m_desc_valid, s_sts_ready}), 64'd0);
        if (hs_pix || hs_wt) begin
          exp_q.push_back(hs_wt ? {1'b1, s_wt_addr, s_wt_len} : {1'b0, s_pix_addr, s_pix_len});
          acc_tags.push_back(hs_wt);
          mph = M_ISSUE;
        end
      end
      M_ISSUE: begin
        check_eq("m_desc_valid", 64'(m_desc_valid), 64'd1);
        check_eq("m_desc_fields", 64'({m_desc_tag, m_desc_addr, m_desc_len}), 64'(exp_q[0]));
        check_eq("issue_quiet", 64'({s_wt_ready, s_pix_ready, s_sts_ready}), 64'd0);
        if (m_desc_ready) begin
          mph = M_WAIT;
          wait_n = 0;
        end
      end
      M_WAIT: begin
        check_eq("wait_ports", 64'({s_sts_ready, m_desc_valid, s_wt_ready, s_pix_ready}), 64'h8);
        wait_n++;
        if (s_sts_valid) finish_desc(s_sts_err, 1'b0);
`ifdef DESC_TIMEOUT_EN
        else if (wait_n == TO) finish_desc(1'b1, 1'b1);
`endif
      end
      default: ;
    endcase
  endtask

  task automatic drive();
    if (hs_pix) s_pix_valid = 1'b0;
    if (hs_wt)  s_wt_valid  = 1'b0;
    if (!s_pix_valid && $urandom_range(99) < p_pix) begin
      s_pix_valid = 1'b1;
      s_pix_addr  = $urandom;
      s_pix_len   = LW'($urandom);
    end
    if (!s_wt_valid && $urandom_range(99) < p_wt) begin
      s_wt_valid = 1'b1;
      s_wt_addr  = $urandom;
      s_wt_len   = LW'($urandom);
    end
    m_desc_ready = ($urandom_range(99) < p_mrdy);
    s_sts_valid  = ($urandom_range(99) < p_sts);
    s_sts_err    = ($urandom_range(99) < p_err);
    hs_pix = 0;
    hs_wt  = 0;
  endtask

  task automatic step();
    @(negedge aclk);
    monitor();
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic apply_reset();
    @(posedge aclk);
    #2;
    aresetn = 1'b0;
    s_pix_valid = 1'b0;
    s_wt_valid = 1'b0;
    m_desc_ready = 1'b0;
    s_sts_valid = 1'b0;
    s_sts_err = 1'b0;
    hs_pix = 0;
    hs_wt = 0;
    #1;
    check_eq("rst_ctrl", 64'({s_pix_ready, s_wt_ready, m_desc_valid, s_sts_ready,
                              pix_done, wt_done, done_err, busy, timeout_flag}), 64'd0);
    check_eq("rst_counts", 64'({pix_count, wt_count}), 64'd0);
    check_eq("rst_desc", 64'({m_desc_tag, m_desc_addr, m_desc_len}), 64'd0);
    model_reset();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
  endtask

  task automatic set_knobs(input int pp, input int pw, input int pm, input int ps, input int pe);
    p_pix = pp; p_wt = pw; p_mrdy = pm; p_sts = ps; p_err = pe;
  endtask

  initial begin
    int guard;
    s_pix_valid = 0; s_wt_valid = 0; s_pix_addr = '0; s_wt_addr = '0;
    s_pix_len = '0; s_wt_len = '0; m_desc_ready = 0; s_sts_valid = 0; s_sts_err = 0;
    n_total = 0;
    set_knobs(0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge aclk);
    apply_reset();

    // Both requesters at once right after reset: weights first, then pixels.
    set_knobs(0, 0, 100, 100, 0);
    s_pix_valid = 1; s_pix_addr = 32'h1000_0040; s_pix_len = 23'h100;
    s_wt_valid = 1;  s_wt_addr = 32'h2000_0080;  s_wt_len = 23'h7f_ffff;
    m_desc_ready = 1;
    repeat (12) step();
    check_eq("first_grant_wt", 64'(acc_tags[0]), 64'd1);
    check_eq("second_grant_pix", 64'(acc_tags[1]), 64'd0);

    // Pixel-only with the DMA stalling: descriptor held stable until taken.
    apply_reset();
    set_knobs(0, 0, 0, 0, 0);
    s_pix_valid = 1; s_pix_addr = 32'hdead_beef; s_pix_len = 23'h12345;
    step();
    repeat (5) step();
    check_eq("issue_held", 64'(mph == M_ISSUE), 64'd1);
    set_knobs(0, 0, 100, 100, 0);
    repeat (6) step();
    check_eq("pix_count_one", 64'(pix_count), 64'd1);

    // Error status on a weight descriptor.
    set_knobs(0, 0, 100, 100, 100);
    s_wt_valid = 1; s_wt_addr = 32'h0000_1000; s_wt_len = 23'h40;
    repeat (6) step();
    check_eq("wt_count_err", 64'(wt_count), 64'd1);

    // Status withheld: watchdog fires if built in, otherwise the block waits.
    set_knobs(0, 0, 100, 0, 0);
    s_sts_valid = 0;
    s_wt_valid = 1; s_wt_addr = 32'h0000_2000; s_wt_len = 23'h80;
    repeat (30) step();
`ifdef DESC_TIMEOUT_EN
    check_eq("timeout_flag_set", 64'(timeout_flag), 64'd1);
    check_eq("wt_count_tmo", 64'(wt_count), 64'd2);
`else
    check_eq("still_waiting", 64'(busy), 64'd1);
    check_eq("no_timeout_flag", 64'(timeout_flag), 64'd0);
`endif
    set_knobs(0, 0, 100, 100, 0);
    repeat (4) step();

    // Reset while waiting for status: descriptor dropped, pointer back to weights.
    set_knobs(0, 0, 100, 0, 0);
    s_pix_valid = 1; s_pix_addr = 32'h0000_3000; s_pix_len = 23'h10;
    guard = 0;
    while (mph != M_WAIT && guard < 50) begin
      step();
      guard++;
    end
    check_eq("reach_wait", 64'(mph == M_WAIT), 64'd1);
    step();
    apply_reset();
    set_knobs(0, 0, 100, 100, 0);
    s_pix_valid = 1; s_pix_addr = 32'h0000_4000; s_pix_len = 23'h20;
    s_wt_valid = 1;  s_wt_addr = 32'h0000_5000;  s_wt_len = 23'h30;
    repeat (4) step();
    check_eq("grant_after_rst", 64'(acc_tags[0]), 64'd1);

    // Sixteen pixel completions wrap the 4-bit counter back to zero.
    apply_reset();
    set_knobs(100, 0, 100, 100, 50);
    guard = 0;
    while (n_pix < 16 && guard < 400) begin
      step();
      guard++;
    end
    check_eq("pix_wrap", 64'(pix_count), 64'd0);
    check_eq("pix_wrap_reached", 64'(n_pix), 64'd16);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0)
        set_knobs($urandom_range(10, 90), $urandom_range(10, 90), $urandom_range(20, 100),
                  $urandom_range(5, 80), $urandom_range(0, 50));
      if (i == 1500) apply_reset();
      step();
    end
    check_eq("progress", 64'(n_total > 100), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
